frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
Ping-pong manager for the two SPRAM frame banks shared by the camera capture writer and spi_slave_camera.
- Allocates a FREE bank to each incoming camera frame.
- Hands completed frames to the SPI reader oldest-first through buffer_ready / frame_read_complete.
- Forms full SPRAM addresses by prefixing the bank bit.
- Counts frames dropped because no bank was free.

Parameters:
FRAME_ADDR_W, 16, per-bank byte address width; SPRAM address width = FRAME_ADDR_W+1
DROP_CNT_W, 16, width of the saturating dropped-frame counter

Ports:
clk  in  1  system clock; all logic on rising edge
nreset  in  1  synchronous active-low reset
cam_frame_start  in  1  one-cycle pulse at camera frame start (VSYNC)
cam_frame_done  in  1  one-cycle pulse after the last pixel byte of the frame is written
cam_wr_addr  in  FRAME_ADDR_W  capture writer's byte offset within the frame
cam_wr_en  out  1  capture may write the current frame
spram_wr_addr  out  FRAME_ADDR_W+1  {wr_bank, cam_wr_addr}, combinational
rd_addr  in  FRAME_ADDR_W  SPI reader's byte offset
spram_rd_addr  out  FRAME_ADDR_W+1  {rd_bank, rd_addr}, combinational
buffer_ready  out  1  a full bank is granted to the SPI reader
frame_read_complete  in  1  one-cycle pulse from the reader at end of frame
frames_dropped  out  DROP_CNT_W  saturating count of dropped frames
bank_state  out  4  {state[1], state[0]}, debug

Behaviour:
- Per-bank state: FREE(0), FILLING(1), FULL(2), DRAINING(3).
- Invariants: at most one bank FILLING; at most one bank DRAINING.
- Registers: wr_bank, rd_bank, older (index of the earlier-completed FULL bank).
- Reset (nreset low at a clk edge):
  - both banks FREE
  - cam_wr_en=0, buffer_ready=0, wr_bank=0, rd_bank=0, older=0, frames_dropped=0
  - takes effect mid-frame or mid-read; in-flight frames are discarded.
- All state and outputs except the address muxes update on the edge after the triggering pulse (1-cycle latency).
- Writer side, cam_frame_start:
  - If a bank is FILLING, that bank first returns to FREE (aborted frame; not counted as a drop).
  - Then allocate the lowest-index FREE bank: -> FILLING, wr_bank=index, cam_wr_en=1.
  - No FREE bank: cam_wr_en=0, frames_dropped += 1, saturating at all-ones.
- Writer side, cam_frame_done:
  - FILLING bank -> FULL, cam_wr_en=0.
  - If the other bank is not FULL, older = this bank.
  - Ignored if no bank is FILLING.
- Same-cycle cam_frame_done and cam_frame_start: done is applied first, then start allocates.
- Reader side, grant:
  - When buffer_ready=0, no bank DRAINING, and at least one FULL bank exists: choose `older` if FULL, else the single FULL bank.
  - Chosen bank -> DRAINING, rd_bank set, buffer_ready=1 on the next edge.
- Reader side, release:
  - frame_read_complete while buffer_ready=1: DRAINING bank -> FREE, buffer_ready=0.
  - No grant in the same cycle, so buffer_ready is low for at least one cycle between frames.
  - If the other bank is FULL, older = other bank.
  - frame_read_complete while buffer_ready=0 is ignored.
- Same-cycle events:
  - A release and a writer event in the same cycle are both applied.
  - A bank freed by release in cycle N is not allocatable by a cam_frame_start in cycle N (allocation sees pre-release state).
- rd_bank and wr_bank hold their last values when idle.
- spram_*_addr are combinational pass-throughs with the bank bit prefixed.

Optional Feature:
FB_OVERWRITE_EN
- Defined: on cam_frame_start with no FREE bank, if one bank is FULL, that bank is reclaimed -> FILLING (latest-frame policy); frames_dropped still increments.
  - A DRAINING bank is never reclaimed.
  - If both banks are busy with no FULL bank, the frame is dropped.
- Undefined: always drop when no FREE bank.

Decomposition:
- Package fb_pkg:
  - bank_state_t enum (FREE, FILLING, FULL, DRAINING)
  - NUM_BANKS=2
  - encoding constants for bank_state packing
- One sub-module, sat_counter (parameter WIDTH; inc, clear, q), used for frames_dropped.
- Bank state machines stay inline.

Test Plan:
- Reset, then cam_frame_start, then 100 cycles later cam_frame_done -> cam_wr_en=1 from the cycle after start, wr_bank=0; buffer_ready=1 within 2 cycles of done with rd_bank=0; rd_addr=16'h0123 -> spram_rd_addr=17'h00123.
- Frame A to bank 0, frame B to bank 1, both done before any read -> first grant rd_bank=0; after frame_read_complete, buffer_ready low at least 1 cycle, then rd_bank=1.
- Both banks FULL/DRAINING, third cam_frame_start -> cam_wr_en=0, frames_dropped=1 (with FB_OVERWRITE_EN: non-draining FULL bank -> FILLING, wr_bank=that bank, frames_dropped=1).
- cam_frame_start twice with no done in between -> bank 0 aborted to FREE and reallocated, wr_bank=0, frames_dropped=0.
- nreset low mid-read with buffer_ready=1 -> next edge buffer_ready=0, bank_state=4'h0, frames_dropped=0; frame_read_complete afterwards ignored.
- Force frames_dropped to 16'hFFFF with repeated drops -> value stays 16'hFFFF.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-bank ping-pong controller.
package fb_pkg;

    localparam int unsigned NUM_BANKS         = 2;
    localparam int unsigned BANK_STATE_W      = 2;
    localparam int unsigned BANK_STATE_VEC_W  = NUM_BANKS * BANK_STATE_W;

    typedef enum logic [BANK_STATE_W-1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (inc && (q_q != MAX_VAL)) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong manager for two SPRAM frame banks shared by the camera writer and
// the SPI reader. Completed frames are handed out oldest-first.
// Optional macro FB_OVERWRITE_EN: when no bank is free at frame start, reclaim
// the oldest FULL bank for the new frame instead of only dropping it.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_ADDR_W = 16,
    parameter int unsigned DROP_CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    cam_frame_start,
    input  logic                    cam_frame_done,
    input  logic [FRAME_ADDR_W-1:0] cam_wr_addr,
    output logic                    cam_wr_en,
    output logic [FRAME_ADDR_W:0]   spram_wr_addr,
    input  logic [FRAME_ADDR_W-1:0] rd_addr,
    output logic [FRAME_ADDR_W:0]   spram_rd_addr,
    output logic                    buffer_ready,
    input  logic                    frame_read_complete,
    output logic [DROP_CNT_W-1:0]   frames_dropped,
    output logic [3:0]              bank_state
);

    bank_state_t st_q [NUM_BANKS];
    bank_state_t st_d [NUM_BANKS];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        older_q, older_d;
    logic        cam_wr_en_q, cam_wr_en_d;
    logic        buffer_ready_q, buffer_ready_d;
    logic        drop_inc;

    logic        any_full;
    logic        any_draining;
    logic        fill_found;
    logic        fill_idx;
    logic        grant;
    logic        grant_bank;
    logic        release_rd;
`ifdef FB_OVERWRITE_EN
    logic        reclaim_bank;
`endif

    // Bank lifecycle: done, then grant, then start (abort + allocate), then release.
    // Allocation runs before release so a bank freed this cycle is not reused.
    always_comb begin
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
            st_d[i] = st_q[i];
        end
        wr_bank_d      = wr_bank_q;
        rd_bank_d      = rd_bank_q;
        older_d        = older_q;
        cam_wr_en_d    = cam_wr_en_q;
        buffer_ready_d = buffer_ready_q;
        drop_inc       = 1'b0;
`ifdef FB_OVERWRITE_EN
        reclaim_bank   = 1'b0;
`endif

        any_full     = (st_q[0] == BANK_FULL) || (st_q[1] == BANK_FULL);
        any_draining = (st_q[0] == BANK_DRAINING) || (st_q[1] == BANK_DRAINING);
        fill_found   = (st_q[0] == BANK_FILLING) || (st_q[1] == BANK_FILLING);
        fill_idx     = (st_q[1] == BANK_FILLING);
        grant        = !buffer_ready_q && !any_draining && any_full;
        grant_bank   = (st_q[older_q] == BANK_FULL) ? older_q : ~older_q;
        release_rd   = frame_read_complete && buffer_ready_q;

        // Frame completion: the filling bank becomes a candidate for reading.
        if (cam_frame_done && fill_found) begin
            st_d[fill_idx] = BANK_FULL;
            cam_wr_en_d    = 1'b0;
            if (st_q[~fill_idx] != BANK_FULL) begin
                older_d = fill_idx;
            end
        end

        // Reader grant of the oldest full bank.
        if (grant) begin
            st_d[grant_bank] = BANK_DRAINING;
            rd_bank_d        = grant_bank;
            buffer_ready_d   = 1'b1;
        end

        // Frame start: abort any in-progress frame, then allocate.
        if (cam_frame_start) begin
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                if (st_d[i] == BANK_FILLING) begin
                    st_d[i] = BANK_FREE;
                end
            end
            if (st_d[0] == BANK_FREE) begin
                st_d[0]     = BANK_FILLING;
                wr_bank_d   = 1'b0;
                cam_wr_en_d = 1'b1;
            end else if (st_d[1] == BANK_FREE) begin
                st_d[1]     = BANK_FILLING;
                wr_bank_d   = 1'b1;
                cam_wr_en_d = 1'b1;
            end else begin
                drop_inc    = 1'b1;
                cam_wr_en_d = 1'b0;
`ifdef FB_OVERWRITE_EN
                reclaim_bank = (st_d[older_q] == BANK_FULL) ? older_q : ~older_q;
                if (st_d[reclaim_bank] == BANK_FULL) begin
                    st_d[reclaim_bank] = BANK_FILLING;
                    wr_bank_d          = reclaim_bank;
                    cam_wr_en_d        = 1'b1;
                    if (st_d[~reclaim_bank] == BANK_FULL) begin
                        older_d = ~reclaim_bank;
                    end
                end
`endif
            end
        end

        // Reader release: draining bank returns to the free pool.
        if (release_rd) begin
            st_d[rd_bank_q] = BANK_FREE;
            buffer_ready_d  = 1'b0;
            if (st_d[~rd_bank_q] == BANK_FULL) begin
                older_d = ~rd_bank_q;
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                st_q[i] <= BANK_FREE;
            end
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            older_q        <= 1'b0;
            cam_wr_en_q    <= 1'b0;
            buffer_ready_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                st_q[i] <= st_d[i];
            end
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            older_q        <= older_d;
            cam_wr_en_q    <= cam_wr_en_d;
            buffer_ready_q <= buffer_ready_d;
        end
    end

    // Dropped-frame counter, cleared with the rest of the controller.
    sat_counter #(
        .WIDTH (DROP_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .clear (~nreset),
        .inc   (drop_inc),
        .q     (frames_dropped)
    );

    assign cam_wr_en     = cam_wr_en_q;
    assign buffer_ready  = buffer_ready_q;
    assign spram_wr_addr = {wr_bank_q, cam_wr_addr};
    assign spram_rd_addr = {rd_bank_q, rd_addr};
    assign bank_state    = {BANK_STATE_W'(st_q[1]), BANK_STATE_W'(st_q[0])};

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl: a queue-based frame model predicts
// each post-edge output set; a monitor pops and compares after every edge.
// A second instance with a 4-bit drop counter exercises saturation cheaply.
module tb_frame_buffer_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nreset = 1'b0;
    logic          cam_frame_start = 1'b0;
    logic          cam_frame_done = 1'b0;
    logic          frame_read_complete = 1'b0;
    logic [AW-1:0] cam_wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;

    logic          cam_wr_en, cam_wr_en_s;
    logic [AW:0]   spram_wr_addr, spram_wr_addr_s;
    logic [AW:0]   spram_rd_addr, spram_rd_addr_s;
    logic          buffer_ready, buffer_ready_s;
    logic [DW-1:0] frames_dropped;
    logic [SW-1:0] frames_dropped_s;
    logic [3:0]    bank_state, bank_state_s;

    frame_buffer_ctrl #(.FRAME_ADDR_W(AW), .DROP_CNT_W(DW)) dut (
        .clk(clk), .nreset(nreset),
        .cam_frame_start(cam_frame_start), .cam_frame_done(cam_frame_done),
        .cam_wr_addr(cam_wr_addr), .cam_wr_en(cam_wr_en), .spram_wr_addr(spram_wr_addr),
        .rd_addr(rd_addr), .spram_rd_addr(spram_rd_addr), .buffer_ready(buffer_ready),
        .frame_read_complete(frame_read_complete), .frames_dropped(frames_dropped),
        .bank_state(bank_state)
    );

    frame_buffer_ctrl #(.FRAME_ADDR_W(AW), .DROP_CNT_W(SW)) dut_sat (
        .clk(clk), .nreset(nreset),
        .cam_frame_start(cam_frame_start), .cam_frame_done(cam_frame_done),
        .cam_wr_addr(cam_wr_addr), .cam_wr_en(cam_wr_en_s), .spram_wr_addr(spram_wr_addr_s),
        .rd_addr(rd_addr), .spram_rd_addr(spram_rd_addr_s), .buffer_ready(buffer_ready_s),
        .frame_read_complete(frame_read_complete), .frames_dropped(frames_dropped_s),
        .bank_state(bank_state_s)
    );

    typedef struct {
        logic          wen;
        logic          brdy;
        logic [AW:0]   waddr;
        logic [AW:0]   raddr;
        logic [DW-1:0] drops;
        logic [SW-1:0] drops_s;
        logic [3:0]    bstate;
    } exp_t;

    exp_t expq[$];

    int n_vec = 0;
    int n_bad = 0;

    // Frame-level model: one filling bank, one draining bank, FIFO of full banks.
    int     m_fill = -1;
    int     m_drain = -1;
    int     m_fullq[$];
    int     m_wr_bank = 0;
    int     m_rd_bank = 0;
    bit     m_wen = 1'b0;
    bit     m_brdy = 1'b0;
    longint m_drops = 0;

    bit            ra_fixed = 1'b0;
    logic [AW-1:0] ra_val = '0;

    function automatic bit in_full(input int b);
        foreach (m_fullq[i]) if (m_fullq[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_free(input int b);
        return (b != m_fill) && (b != m_drain) && !in_full(b);
    endfunction

    function automatic logic [1:0] code_of(input int b);
        if (b == m_fill)  return 2'd1;
        if (b == m_drain) return 2'd3;
        if (in_full(b))   return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit dn, input bit rc);
        bit g;
        bit rel;
        int b;
        if (rst) begin
            m_fill = -1; m_drain = -1; m_fullq.delete();
            m_wr_bank = 0; m_rd_bank = 0; m_wen = 0; m_brdy = 0; m_drops = 0;
            return;
        end
        g   = !m_brdy && (m_drain < 0) && (m_fullq.size() > 0);
        rel = rc && m_brdy;
        if (dn && m_fill >= 0) begin
            m_fullq.push_back(m_fill);
            m_fill = -1;
            m_wen  = 0;
        end
        if (g) begin
            m_drain   = m_fullq.pop_front();
            m_rd_bank = m_drain;
            m_brdy    = 1;
        end
        if (st) begin
            m_fill = -1;
            b = -1;
            for (int i = 1; i >= 0; i--) if (is_free(i)) b = i;
            if (b >= 0) begin
                m_fill = b; m_wr_bank = b; m_wen = 1;
            end else begin
                m_drops++;
                m_wen = 0;
`ifdef FB_OVERWRITE_EN
                if (m_fullq.size() > 0) begin
                    m_fill    = m_fullq.pop_front();
                    m_wr_bank = m_fill;
                    m_wen     = 1;
                end
`endif
            end
        end
        if (rel) begin
            m_drain = -1;
            m_brdy  = 0;
        end
    endtask

    // One clock of stimulus; the expected post-edge outputs go on the scoreboard.
    task automatic cyc(input bit rst, input bit st, input bit dn, input bit rc);
        exp_t e;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        @(negedge clk);
        wa = AW'($urandom);
        ra = ra_fixed ? ra_val : AW'($urandom);
        nreset = !rst; cam_frame_start = st; cam_frame_done = dn; frame_read_complete = rc;
        cam_wr_addr = wa; rd_addr = ra;
        model_step(rst, st, dn, rc);
        e.wen     = m_wen;
        e.brdy    = m_brdy;
        e.waddr   = {1'(m_wr_bank), wa};
        e.raddr   = {1'(m_rd_bank), ra};
        e.drops   = (m_drops > 64'd65535) ? DW'(16'hFFFF) : DW'(m_drops);
        e.drops_s = (m_drops > 64'd15) ? SW'(4'hF) : SW'(m_drops);
        e.bstate  = {code_of(1), code_of(0)};
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: after every active edge, compare all outputs with the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("cam_wr_en",        32'(cam_wr_en),        32'(e.wen));
            check("buffer_ready",     32'(buffer_ready),     32'(e.brdy));
            check("spram_wr_addr",    32'(spram_wr_addr),    32'(e.waddr));
            check("spram_rd_addr",    32'(spram_rd_addr),    32'(e.raddr));
            check("frames_dropped",   32'(frames_dropped),   32'(e.drops));
            check("bank_state",       32'(bank_state),       32'(e.bstate));
            check("sat_cam_wr_en",    32'(cam_wr_en_s),      32'(e.wen));
            check("sat_buffer_ready", 32'(buffer_ready_s),   32'(e.brdy));
            check("sat_wr_addr",      32'(spram_wr_addr_s),  32'(e.waddr));
            check("sat_rd_addr",      32'(spram_rd_addr_s),  32'(e.raddr));
            check("sat_frames_dropped", 32'(frames_dropped_s), 32'(e.drops_s));
            check("sat_bank_state",   32'(bank_state_s),     32'(e.bstate));
        end
    end

    initial begin
        // Reset and single frame with a fixed read offset.
        ra_fixed = 1'b1; ra_val = 16'h0123;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        idle(100);
        cyc(0, 0, 1, 0);
        idle(4);
        cyc(0, 0, 0, 1);
        idle(3);
        ra_fixed = 1'b0;

        // Two frames completed before any read: oldest first, gap between grants.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); idle(5); cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0); idle(5); cyc(0, 0, 1, 0);
        idle(3);
        cyc(0, 0, 0, 1); idle(4);
        cyc(0, 0, 0, 1); idle(3);

        // Both banks busy, third frame start is dropped (or reclaims).
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); idle(2); cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0); idle(2); cyc(0, 0, 1, 0);
        idle(3);
        cyc(0, 1, 0, 0); idle(3);

        // Back-to-back starts abort and reallocate bank 0.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); idle(3); cyc(0, 1, 0, 0); idle(3);

        // Same-cycle done and start, and release together with a writer event.
        cyc(0, 1, 1, 0); idle(3); cyc(0, 0, 1, 0); idle(2);
        cyc(0, 1, 0, 1); idle(2);

        // Reset in the middle of a read; a late read-complete is ignored.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); idle(3); cyc(0, 0, 1, 0); idle(3);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1); idle(2);

        // Repeated drops with both banks held: small counter saturates.
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 24; i++) cyc(0, 1, 0, 0);
        idle(2);

        // Randomized traffic.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 5) == 0));
        end
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
